multicycle_control: RTL
=======================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameter OPCODE_W, 4, opcode width; SHALL be >=4; any nonzero bit above bit 3 marks the opcode illegal.
REQ-002 Parameter CNT_W, 32, width of both performance counters.
REQ-003 Parameter ENABLE_BNE, 1, when 0 the BNE opcode SHALL be decoded as illegal.
REQ-004 One clock; reset is asynchronous and active-low.
REQ-005 Clock  in  1  rising-edge system clock.
REQ-006 Reset_n  in  1  asynchronous active-low reset.
REQ-007 opcode  in  OPCODE_W  instruction opcode from the instruction register, valid from the DECODE cycle.
REQ-008 mem_ready  in  1  memory completion handshake, sampled in FETCH/MEMREAD/MEMWRITE.
REQ-009 PCWrite, PCWriteCond, BranchNE, IorD, MemRead, MemWrite, IRWrite, MemToReg, RegDst, RegWrite, ALUSrcA  out  1 each  datapath controls.
REQ-010 ALUSrcB, ALUOp, PCSource  out  2 each  datapath mux/ALU selects.
REQ-011 state  out  4  current FSM state encoding.
REQ-012 Halted, Illegal  out  1  sticky status flags.
REQ-013 cycle_count, instr_count  out  CNT_W  performance counters.

Function
REQ-014 Opcodes SHALL decode as: 0000 R-type, 0001 ADDI, 0010 LW, 0011 SW, 0100 BEQ, 0101 BNE, 0110 J, 1111 HALT; every other value is illegal.
REQ-015 State encodings SHALL be: FETCH 0, DECODE 1, MEMADDR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXEC_R 6, RWB 7, EXEC_I 8, IWB 9, BRANCH 10, JUMP 11, HALT 12, TRAP 13; encodings 14-15 SHALL return to FETCH on the next edge.
REQ-016 Any control output not listed for a state SHALL be 0.
REQ-017 FETCH: MemRead=1, ALUSrcB=01; IRWrite and PCWrite SHALL equal mem_ready. Stay in FETCH while mem_ready=0; advance to DECODE when mem_ready=1.
REQ-018 DECODE: ALUSrcB=11; latch opcode into an internal register; next state is EXEC_R, EXEC_I, MEMADDR (LW/SW), BRANCH (BEQ/BNE), JUMP, HALT or TRAP per REQ-014.
REQ-019 MEMADDR: ALUSrcA=1, ALUSrcB=10; go to MEMREAD for LW, MEMWRITE for SW.
REQ-020 MEMREAD: MemRead=1, IorD=1; wait for mem_ready, then go to MEMWB. MEMWB: RegWrite=1, MemToReg=1; then go to FETCH.
REQ-021 MEMWRITE: MemWrite=1, IorD=1; wait for mem_ready, then go to FETCH.
REQ-022 EXEC_R: ALUSrcA=1, ALUOp=10; then go to RWB. RWB: RegDst=1, RegWrite=1; then go to FETCH.
REQ-023 EXEC_I: ALUSrcA=1, ALUSrcB=10; then go to IWB. IWB: RegWrite=1; then go to FETCH.
REQ-024 BRANCH: ALUSrcA=1, ALUOp=01, PCWriteCond=1, PCSource=01; BranchNE=1 only for a latched BNE; then go to FETCH.
REQ-025 JUMP: PCWrite=1, PCSource=10; then go to FETCH.
REQ-026 HALT and TRAP SHALL be absorbing until reset, with all controls 0; Halted=1 in HALT, Illegal=1 in TRAP.
REQ-027 Latencies in cycles, with zero memory wait: R/ADDI/LW 4-5, SW 4, BEQ/BNE/J 3; each memory wait cycle adds exactly 1.
REQ-028 cycle_count SHALL increment every cycle the state is neither HALT nor TRAP.
REQ-029 instr_count SHALL increment on every transition into FETCH from another state, and on entry into HALT.
REQ-030 Both counters SHALL wrap modulo 2^CNT_W without flagging.
REQ-031 mem_ready asserted in any state other than FETCH, MEMREAD or MEMWRITE SHALL be ignored.

Reset
REQ-032 While Reset_n=0, state SHALL be FETCH and all controls (including the latched opcode), flags and counters SHALL be 0 immediately, without waiting for Clock.
REQ-033 Reset asserted mid-instruction, including during a memory wait, SHALL abandon the instruction with no further RegWrite, MemWrite or PCWrite.
REQ-034 After Reset_n rises, the first edge SHALL evaluate FETCH.

Verification
REQ-035 R-type with mem_ready held 1: state 0,1,6,7,0; RegWrite=1 only in RWB; instr_count 0->1; cycle_count=4.
REQ-036 LW with mem_ready=0 for 2 cycles in MEMREAD: state 0,1,2,3,3,3,4,0; IorD=1 throughout MEMREAD; MemToReg=1 in MEMWB.
REQ-037 BNE with ENABLE_BNE=1 -> BRANCH, BranchNE=1, PCSource=01. Same opcode with ENABLE_BNE=0 -> TRAP (13), Illegal=1, cycle_count frozen.
REQ-038 Opcode 1111 -> HALT (12), Halted=1; mem_ready toggling has no effect; counters frozen.
REQ-039 With CNT_W=4, run 16 R-type instructions -> instr_count wraps 15->0.
REQ-040 Drop Reset_n in MEMWRITE while mem_ready=0 -> state=0 and MemWrite=0 asynchronously; resume at FETCH after release.

Source files
------------

// File: rtl/multicycle_control.sv
// Multicycle CPU control unit: opcode-driven FSM that sequences the datapath through
// fetch, decode, execute, memory and writeback steps, with sticky halt/trap states and performance counters.
module multicycle_control #(
    parameter int OPCODE_W   = 4,
    parameter int CNT_W      = 32,
    parameter bit ENABLE_BNE = 1'b1
) (
    input  logic                Clock,
    input  logic                Reset_n,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                mem_ready,
    output logic                PCWrite,
    output logic                PCWriteCond,
    output logic                BranchNE,
    output logic                IorD,
    output logic                MemRead,
    output logic                MemWrite,
    output logic                IRWrite,
    output logic                MemToReg,
    output logic                RegDst,
    output logic                RegWrite,
    output logic                ALUSrcA,
    output logic [1:0]          ALUSrcB,
    output logic [1:0]          ALUOp,
    output logic [1:0]          PCSource,
    output logic [3:0]          state,
    output logic                Halted,
    output logic                Illegal,
    output logic [CNT_W-1:0]    cycle_count,
    output logic [CNT_W-1:0]    instr_count
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADDR  = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXEC_R   = 4'd6,
        S_RWB      = 4'd7,
        S_EXEC_I   = 4'd8,
        S_IWB      = 4'd9,
        S_BRANCH   = 4'd10,
        S_JUMP     = 4'd11,
        S_HALT     = 4'd12,
        S_TRAP     = 4'd13
    } state_e;

    localparam logic [3:0] OP_RTYPE = 4'h0;
    localparam logic [3:0] OP_ADDI  = 4'h1;
    localparam logic [3:0] OP_LW    = 4'h2;
    localparam logic [3:0] OP_SW    = 4'h3;
    localparam logic [3:0] OP_BEQ   = 4'h4;
    localparam logic [3:0] OP_BNE   = 4'h5;
    localparam logic [3:0] OP_J     = 4'h6;
    localparam logic [3:0] OP_HALT  = 4'hF;

    state_e           r_state;
    state_e           w_next;
    state_e           w_decoded;
    logic [3:0]       r_opcode;
    logic             w_op_high;
    logic             w_instr_done;
    logic [CNT_W-1:0] r_cycle_count;
    logic [CNT_W-1:0] r_instr_count;

    // Any set bit above the 4-bit opcode field makes the instruction illegal.
    generate
        if (OPCODE_W > 4) begin : g_wide_opcode
            assign w_op_high = |opcode[OPCODE_W-1:4];
        end else begin : g_narrow_opcode
            assign w_op_high = 1'b0;
        end
    endgenerate

    always_comb begin
        w_decoded = S_TRAP;
        if (!w_op_high) begin
            case (opcode[3:0])
                OP_RTYPE:      w_decoded = S_EXEC_R;
                OP_ADDI:       w_decoded = S_EXEC_I;
                OP_LW, OP_SW:  w_decoded = S_MEMADDR;
                OP_BEQ:        w_decoded = S_BRANCH;
                OP_BNE:        w_decoded = ENABLE_BNE ? S_BRANCH : S_TRAP;
                OP_J:          w_decoded = S_JUMP;
                OP_HALT:       w_decoded = S_HALT;
                default:       w_decoded = S_TRAP;
            endcase
        end
    end

    always_comb begin
        w_next = S_FETCH;
        case (r_state)
            S_FETCH:    w_next = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE:   w_next = w_decoded;
            S_MEMADDR:  w_next = (r_opcode == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  w_next = mem_ready ? S_MEMWB : S_MEMREAD;
            S_MEMWB:    w_next = S_FETCH;
            S_MEMWRITE: w_next = mem_ready ? S_FETCH : S_MEMWRITE;
            S_EXEC_R:   w_next = S_RWB;
            S_RWB:      w_next = S_FETCH;
            S_EXEC_I:   w_next = S_IWB;
            S_IWB:      w_next = S_FETCH;
            S_BRANCH:   w_next = S_FETCH;
            S_JUMP:     w_next = S_FETCH;
            S_HALT:     w_next = S_HALT;
            S_TRAP:     w_next = S_TRAP;
            default:    w_next = S_FETCH;
        endcase
    end

    assign w_instr_done = ((w_next == S_FETCH) && (r_state != S_FETCH)) ||
                          ((w_next == S_HALT)  && (r_state != S_HALT));

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state       <= S_FETCH;
            r_opcode      <= '0;
            r_cycle_count <= '0;
            r_instr_count <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_DECODE) begin
                r_opcode <= opcode[3:0];
            end
            if ((r_state != S_HALT) && (r_state != S_TRAP)) begin
                r_cycle_count <= r_cycle_count + CNT_W'(1);
            end
            if (w_instr_done) begin
                r_instr_count <= r_instr_count + CNT_W'(1);
            end
        end
    end

    // NOTE: every output gets a default first so no latch is inferred; reset forces all controls low
    // immediately, even though FETCH would otherwise drive MemRead.
    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        BranchNE    = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemToReg    = 1'b0;
        RegDst      = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        ALUOp       = 2'b00;
        PCSource    = 2'b00;
        if (Reset_n) begin
            case (r_state)
                S_FETCH: begin
                    MemRead = 1'b1;
                    ALUSrcB = 2'b01;
                    IRWrite = mem_ready;
                    PCWrite = mem_ready;
                end
                S_DECODE:   ALUSrcB = 2'b11;
                S_MEMADDR: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = 2'b10;
                end
                S_MEMREAD: begin
                    MemRead = 1'b1;
                    IorD    = 1'b1;
                end
                S_MEMWB: begin
                    RegWrite = 1'b1;
                    MemToReg = 1'b1;
                end
                S_MEMWRITE: begin
                    MemWrite = 1'b1;
                    IorD     = 1'b1;
                end
                S_EXEC_R: begin
                    ALUSrcA = 1'b1;
                    ALUOp   = 2'b10;
                end
                S_RWB: begin
                    RegDst   = 1'b1;
                    RegWrite = 1'b1;
                end
                S_EXEC_I: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = 2'b10;
                end
                S_IWB:      RegWrite = 1'b1;
                S_BRANCH: begin
                    ALUSrcA     = 1'b1;
                    ALUOp       = 2'b01;
                    PCWriteCond = 1'b1;
                    PCSource    = 2'b01;
                    BranchNE    = (r_opcode == OP_BNE);
                end
                S_JUMP: begin
                    PCWrite  = 1'b1;
                    PCSource = 2'b10;
                end
                default: ;
            endcase
        end
    end

    assign state       = r_state;
    assign Halted      = (r_state == S_HALT);
    assign Illegal     = (r_state == S_TRAP);
    assign cycle_count = r_cycle_count;
    assign instr_count = r_instr_count;

endmodule
